// File: rtl/color_pkg.sv
// color_pkg -- shared constants and FSM state type for the colour frame
// assembler.
//   N_SAMPLES : default number of 16-bit channel samples per frame
//   SAMPLE_W  : width of one colour channel sample
//   FRAME_W   : width of a complete presented frame
//   state_t   : assembler FSM states
package color_pkg;

  localparam int N_SAMPLES = 9;
  localparam int SAMPLE_W  = 16;
  localparam int FRAME_W   = N_SAMPLES * SAMPLE_W;

  // COLLECT: taking samples into the working buffer.
  // PEND   : working frame complete, waiting for the presented frame to free up.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PEND    = 1'b1
  } state_t;

endpackage

// File: rtl/color_frame_assembler.sv
// color_frame_assembler -- gathers N_SAMPLES 16-bit colour channel samples
// into a frame and hands complete frames to an SPI shifter with a
// done/frame_ack handshake. Sample index 0 lands in the frame MSBs.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   sample_valid   : upstream sample present
//   sample_ready   : block accepts a sample this cycle (COLLECT state)
//   sample_data    : one colour channel reading
//   sample_sof     : marks sample_data as index 0 of a frame
//   frame_ack      : one-cycle pulse, SPI side consumed the presented frame
//   color          : presented frame (frozen while done=1)
//   done           : color valid and frozen
//   sof_err        : one-cycle pulse when a sof resynchronises a partial frame
module color_frame_assembler #(
  parameter int N_SAMPLES = color_pkg::N_SAMPLES
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     sample_valid,
  output logic                                     sample_ready,
  input  logic [color_pkg::SAMPLE_W-1:0]           sample_data,
  input  logic                                     sample_sof,
  input  logic                                     frame_ack,
  output logic [N_SAMPLES*color_pkg::SAMPLE_W-1:0] color,
  output logic                                     done,
  output logic                                     sof_err
);

  localparam int SW = color_pkg::SAMPLE_W;
  localparam int FW = N_SAMPLES * SW;
  localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  color_pkg::state_t state;
  logic [CW-1:0]     count;
  logic              sof_seen;
  logic [FW-1:0]     work;
  logic [FW-1:0]     work_next;
  logic [CW-1:0]     wr_idx;
  logic              accept;
  logic              take;
  logic              last;

  // Ready is purely a function of the FSM state.
  always_comb begin
    sample_ready = (state == color_pkg::COLLECT);
  end

  // Decode the accept, the slot it writes, and whether it completes a frame.
  // Samples before the first sof after reset are accepted but dropped.
  always_comb begin
    accept = sample_valid && sample_ready;
    take   = accept && (sample_sof || sof_seen);
    wr_idx = sample_sof ? {CW{1'b0}} : count;
    last   = take && (wr_idx == LAST_IDX);
    work_next = work;
    for (int i = 0; i < N_SAMPLES; i++) begin
      work_next[FW-1-SW*i -: SW] = (wr_idx == CW'(i)) ? sample_data
                                                       : work[FW-1-SW*i -: SW];
    end
  end

  // Working buffer, index counter, presentation handshake and FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= color_pkg::COLLECT;
      count    <= {CW{1'b0}};
      sof_seen <= 1'b0;
      work     <= {FW{1'b0}};
      color    <= {FW{1'b0}};
      done     <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      sof_err <= 1'b0;
      if (take) begin
        work  <= work_next;
        count <= last ? {CW{1'b0}} : (wr_idx + CW'(1));
      end
      if (accept && sample_sof) begin
        sof_seen <= 1'b1;
        sof_err  <= (count != {CW{1'b0}});
      end
      case (state)
        color_pkg::COLLECT: begin
          if (frame_ack && done) begin
            done <= 1'b0;
          end
          // Decisions use done as registered before this edge; a frame
          // completing alongside an ack still goes through PEND.
          if (last) begin
            if (!done) begin
              color <= work_next;
              done  <= 1'b1;
            end else begin
              state <= color_pkg::PEND;
            end
          end
        end
        color_pkg::PEND: begin
          if (!done) begin
            color <= work;
            done  <= 1'b1;
            state <= color_pkg::COLLECT;
          end else if (frame_ack) begin
            done <= 1'b0;
          end
        end
        default: begin
          state <= color_pkg::COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_frame_assembler.sv
// Self-checking bench for color_frame_assembler: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_color_frame_assembler;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_valid;
  logic         sample_ready;
  logic [15:0]  sample_data;
  logic         sample_sof;
  logic         frame_ack;
  logic [143:0] color;
  logic         done;
  logic         sof_err;

  color_frame_assembler #(.N_SAMPLES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .sample_sof   (sample_sof),
    .frame_ack    (frame_ack),
    .color        (color),
    .done         (done),
    .sof_err      (sof_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_pulses = 0;

  // Reference model state: samples of the frame in progress, a pending
  // completed frame, the presented frame.
  logic [15:0]  cur[$];
  bit           have_sof;
  bit           pend_v;
  logic [143:0] pend;
  logic [143:0] disp;
  bit           m_done;
  bit           m_err;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] pack_frame();
    logic [143:0] f = '0;
    for (int i = 0; i < N; i++) f = (f << 16) | 144'(cur[i]);
    return f;
  endfunction

  task automatic model_update(input bit v, input logic [15:0] d, input bit s,
                              input bit a, input bit r);
    bit acc;
    bit d_old;
    logic [143:0] f;
    if (r) begin
      cur.delete(); have_sof = 0; pend_v = 0; pend = '0;
      disp = '0; m_done = 0; m_err = 0;
      return;
    end
    acc   = v && !pend_v;
    d_old = m_done;
    m_err = 0;
    if (pend_v) begin
      if (!d_old) begin
        disp = pend; m_done = 1; pend_v = 0;
      end else if (a) begin
        m_done = 0;
      end
    end else begin
      if (a && d_old) m_done = 0;
      if (acc) begin
        if (s) begin
          m_err = (cur.size() != 0);
          cur.delete();
          cur.push_back(d);
          have_sof = 1;
        end else if (have_sof) begin
          cur.push_back(d);
        end
        if (cur.size() == N) begin
          f = pack_frame();
          cur.delete();
          if (!d_old) begin
            disp = f; m_done = 1;
          end else begin
            pend = f; pend_v = 1;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after.
  task automatic step(input bit v, input logic [15:0] d, input bit s,
                      input bit a, input bit r);
    sample_valid = v; sample_data = d; sample_sof = s; frame_ack = a; reset = r;
    @(posedge clk);
    model_update(v, d, s, a, r);
    #1;
    if (sof_err === 1'b1) err_pulses++;
    chk("ready",   144'(sample_ready), 144'(!pend_v));
    chk("done",    144'(done),         144'(m_done));
    chk("sof_err", 144'(sof_err),      144'(m_err));
    chk("color",   color,              disp);
  endtask

  task automatic send_frame(input logic [15:0] base, input bit ack_last);
    for (int i = 0; i < N; i++)
      step(1'b1, base + 16'(i), i == 0, ack_last && (i == N - 1), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    sample_valid = 1'b0; sample_data = 16'h0000; sample_sof = 1'b0;
    frame_ack = 1'b0; reset = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("rst_ready", 144'(sample_ready), 144'(1));

    // Samples without sof after reset are dropped.
    err_pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h5550 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("nosof_done", 144'(done), 144'(0));
    chk("nosof_err", 144'(err_pulses), 144'(0));

    // First frame presented on the edge of its last sample.
    send_frame(16'h0001, 1'b0);
    chk("f1_done", 144'(done), 144'(1));
    chk("f1_color", color, 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009);

    // Second frame while first is still presented -> PEND, then handover.
    send_frame(16'h00A1, 1'b0);
    idle(2);
    chk("f2_ready", 144'(sample_ready), 144'(0));
    chk("f2_hold", color, 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("f2_gap", 144'(done), 144'(0));
    idle(1);
    chk("f2_done", 144'(done), 144'(1));
    chk("f2_color", color, 144'h00A1_00A2_00A3_00A4_00A5_00A6_00A7_00A8_00A9);

    // Partial frame resynchronised by a new sof.
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    err_pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0B00 + 16'(i), i == 0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("resync_pulses", 144'(err_pulses), 144'(1));
    chk("resync_msb", 144'(color[143:128]), 144'(16'hBEEF));

    // Ack on the same edge as the last sample of the next frame.
    send_frame(16'h00C1, 1'b1);
    chk("same_edge_gap", 144'(done), 144'(0));
    idle(1);
    chk("same_edge_done", 144'(done), 144'(1));
    chk("same_edge_color", color, 144'h00C1_00C2_00C3_00C4_00C5_00C6_00C7_00C8_00C9);

    // Reset mid-frame discards everything.
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0D00 + 16'(i), i == 0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("midrst_done", 144'(done), 144'(0));
    chk("midrst_color", color, 144'h0);
    send_frame(16'h0001, 1'b0);
    chk("post_rst_color", color, 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
